regfile_port_ctrl: RTL and testbench
====================================

// Module: regfile_port_ctrl
// PURPOSE
//  Controller for the 32x32 register file's single write port (WE3/A3/WD3).
//  After reset it sequences a zero-fill of every register, as the storage array has no reset.
//  It then shares the write port between core writeback and a debug/loader write requester.
//  It sits between the core writeback path and reg_file, and drives WE3/A3/WD3 directly.
// PARAMETERS
//  NREGS     32            number of registers swept by the init sequence
//  AW        5             register address width
//  DW        32            data width
//  INIT_VAL  32'h00000000  value written to every register during init
// PORTS
//  clk            in   1   single clock; all state changes on its rising edge
//  rst            in   1   asynchronous, active-low reset
//  init_req       in   1   pulse in RUN: restart the zero-fill sweep
//  core_we        in   1   core writeback enable
//  core_addr      in   AW  core writeback register index
//  core_data      in   DW  core writeback data
//  core_stall     out  1   core must hold PC/writeback this cycle
//  dbg_valid      in   1   debug write request
//  dbg_addr       in   AW  debug write register index
//  dbg_data       in   DW  debug write data
//  dbg_ready      out  1   debug write accepted this cycle (valid && ready)
//  rf_we          out  1   to reg_file WE3
//  rf_addr        out  AW  to reg_file A3
//  rf_wd          out  DW  to reg_file WD3
//  init_done      out  1   high in RUN
//  conflict_cnt   out  16  saturating count of stalled-request cycles
// BEHAVIOUR
//  - States: INIT, RUN. rst low: state=INIT, cnt=0, conflict_cnt=0; rf_we, dbg_ready, init_done=0; core_stall=1.
//  - rf_we, rf_addr and rf_wd are combinational muxes with zero added latency. The write lands on the same clk edge as the grant.
//  - INIT: rf_we=1, rf_addr=cnt, rf_wd=INIT_VAL; cnt++ each cycle. core_stall=1, dbg_ready=0.
//    At cnt==NREGS-1 the state becomes RUN on the next edge, so INIT lasts exactly NREGS cycles.
//    init_done rises on the first RUN cycle.
//  - RUN, core only: rf_we=core_we, rf_addr=core_addr, rf_wd=core_data.
//  - RUN, debug only: dbg_ready=1 when core_we=0. The debug write is forwarded in the same cycle.
//    The requester holds dbg_valid, dbg_addr and dbg_data stable until it sees dbg_ready.
//  - x0 protect: a granted write with address 0 drives rf_we=0.
//    A debug request to x0 is still acknowledged (dbg_ready=1) and discarded.
//  - Both requesting in RUN: arbitration follows the CONFIGURATION block.
//    The loser is stalled: core via core_stall=1, debug via dbg_ready=0.
//    conflict_cnt increments for each such cycle and saturates at 16'hFFFF.
//  - init_req in RUN: the current-cycle grant completes. The next edge sets state=INIT and cnt=0.
//    init_req is ignored while in INIT.
//  - rst asserted at any point, including mid-INIT: the sweep restarts from cnt=0 on release.
// CONFIGURATION
//  REGCTRL_RR_EN defined: round-robin between core and debug. A 1-bit last_grant flag sets priority.
//    The flag resets to debug-granted, so the core wins the first conflict.
//    Each conflict is granted to the requester not granted last, and core_stall=1 on cycles the core loses.
//  REGCTRL_RR_EN undefined: fixed priority, core always wins. core_stall=0 throughout RUN.
//    Debug can starve, and conflict_cnt records it.
// TESTING
//  1. Release rst -> rf_we=1 with rf_addr 0..31 on consecutive cycles and rf_wd=0.
//     init_done=1 on cycle 32; all 32 registers read back 0.
//  2. RUN, core_we=1, addr=5, data=32'hDEADBEEF -> rf_we=1, rf_addr=5 in the same cycle; x5 reads DEADBEEF.
//  3. Fixed priority, core_we and dbg_valid both high for 3 cycles -> dbg_ready=0 and core_stall=0 throughout.
//     conflict_cnt=3; the debug write lands on the 4th cycle, when core_we=0.
//  4. REGCTRL_RR_EN, both requesting continuously -> grants alternate core, dbg, core, dbg.
//     core_stall=1 exactly on the dbg-grant cycles.
//  5. Core write to x0 with 32'h1234 -> rf_we=0.
//     Debug write to x0 -> dbg_ready=1, rf_we=0, and x0 still reads 0.
//  6. rst pulsed low at cnt=10 -> outputs at reset values. After release the sweep restarts at addr 0 and takes 32 cycles.
//     init_req in RUN -> INIT next cycle and init_done=0.

Source files
------------

// File: rtl/regfile_port_ctrl.sv
// Write-port controller for the 32x32 register file: zero-fill sweep after reset, then core/debug sharing.
// Optional build macro REGCTRL_RR_EN selects round-robin arbitration; otherwise the core always wins.
module regfile_port_ctrl #(
  parameter int          NREGS    = 32,
  parameter int          AW       = 5,
  parameter int          DW       = 32,
  parameter logic [DW-1:0] INIT_VAL = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          init_req,
  input  logic          core_we,
  input  logic [AW-1:0] core_addr,
  input  logic [DW-1:0] core_data,
  output logic          core_stall,
  input  logic          dbg_valid,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_data,
  output logic          dbg_ready,
  output logic          rf_we,
  output logic [AW-1:0] rf_addr,
  output logic [DW-1:0] rf_wd,
  output logic          init_done,
  output logic [15:0]   conflict_cnt
);

  typedef enum logic {INIT, RUN} state_t;

  localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

  state_t        state;
  logic [AW-1:0] cnt;
  logic          conflict;
  logic          dbg_wins;
  logic          core_grant;
  logic          dbg_grant;

  assign conflict = (state == RUN) && core_we && dbg_valid;

`ifdef REGCTRL_RR_EN
  logic last_grant;  // 1: core won the previous conflict, 0: debug did

  assign dbg_wins = conflict && last_grant;
`else
  assign dbg_wins = 1'b0;
`endif

  assign core_grant = (state == RUN) && core_we && !dbg_wins;
  assign dbg_grant  = (state == RUN) && dbg_valid && (!core_we || dbg_wins);

  // NOTE: every output gets a default before any branch so no path leaves it unassigned (no latches).
  always_comb begin
    core_stall = 1'b1;
    dbg_ready  = 1'b0;
    rf_we      = 1'b0;
    rf_addr    = core_addr;
    rf_wd      = core_data;
    if (state == INIT) begin
      // The port stays quiet while reset is held; the sweep starts on the first edge after release.
      rf_we   = rst;
      rf_addr = cnt;
      rf_wd   = INIT_VAL;
    end else begin
      core_stall = dbg_wins;
      dbg_ready  = dbg_grant;
      if (dbg_grant) begin
        rf_we   = (dbg_addr != '0);
        rf_addr = dbg_addr;
        rf_wd   = dbg_data;
      end else begin
        rf_we = core_grant && (core_addr != '0);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= INIT;
      cnt          <= '0;
      init_done    <= 1'b0;
      conflict_cnt <= '0;
`ifdef REGCTRL_RR_EN
      last_grant   <= 1'b0;
`endif
    end else begin
      case (state)
        INIT: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST_IDX) begin
            state     <= RUN;
            init_done <= 1'b1;
            cnt       <= '0;
          end
        end
        RUN: begin
          if (conflict && (conflict_cnt != 16'hFFFF)) begin
            conflict_cnt <= conflict_cnt + 16'd1;
          end
`ifdef REGCTRL_RR_EN
          if (conflict) begin
            last_grant <= ~last_grant;
          end
`endif
          if (init_req) begin
            state     <= INIT;
            cnt       <= '0;
            init_done <= 1'b0;
          end
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_port_ctrl.sv
// Scoreboard bench for regfile_port_ctrl: stimulus pushes expected writes, a negedge monitor pops and compares.
module tb_regfile_port_ctrl;
  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int NREGS = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          init_req;
  logic          core_we;
  logic [AW-1:0] core_addr;
  logic [DW-1:0] core_data;
  logic          core_stall;
  logic          dbg_valid;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_data;
  logic          dbg_ready;
  logic          rf_we;
  logic [AW-1:0] rf_addr;
  logic [DW-1:0] rf_wd;
  logic          init_done;
  logic [15:0]   conflict_cnt;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t           exp_q[$];
  logic [DW-1:0] rf_model[NREGS];
  int            n_cmp = 0;
  int            n_err = 0;

  regfile_port_ctrl dut (
    .clk(clk), .rst(rst), .init_req(init_req),
    .core_we(core_we), .core_addr(core_addr), .core_data(core_data), .core_stall(core_stall),
    .dbg_valid(dbg_valid), .dbg_addr(dbg_addr), .dbg_data(dbg_data), .dbg_ready(dbg_ready),
    .rf_we(rf_we), .rf_addr(rf_addr), .rf_wd(rf_wd),
    .init_done(init_done), .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Stand-in for the reg_file storage, written exactly as the real array would be.
  initial for (int i = 0; i < NREGS; i++) rf_model[i] = 32'hBAD0_0000 + 32'(i);
  always @(posedge clk) if (rst === 1'b1 && rf_we === 1'b1) rf_model[rf_addr] <= rf_wd;

  always @(negedge clk) begin : monitor
    wr_t e;
    if (rst === 1'b1 && rf_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_write: got addr %0d data %h expected no write", rf_addr, rf_wd);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 32'(rf_addr), 32'(e.addr));
        check("wr_data", rf_wd, e.data);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    exp_q.push_back(w);
  endtask

  task automatic push_sweep();
    for (int i = 0; i < NREGS; i++) push(AW'(i), 32'h0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    core_we   = 1'b0;
    dbg_valid = 1'b0;
    init_req  = 1'b0;
  endtask

  task automatic check_swept(input string name);
    int bad = 0;
    for (int i = 0; i < NREGS; i++) if (rf_model[i] !== 32'h0) bad++;
    check(name, 32'(bad), 32'd0);
  endtask

  initial begin
    rst = 1'b0;
    idle();
    core_addr = '0; core_data = '0; dbg_addr = '0; dbg_data = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_init_done", 32'(init_done), 32'd0);
    check("rst_core_stall", 32'(core_stall), 32'd1);
    check("rst_dbg_ready", 32'(dbg_ready), 32'd0);
    check("rst_rf_we", 32'(rf_we), 32'd0);
    check("rst_conflict_cnt", 32'(conflict_cnt), 32'd0);

    // Zero-fill sweep: 32 writes, RUN on cycle 32
    step();
    push_sweep();
    rst = 1'b1;
    for (int i = 0; i < NREGS; i++) begin
      @(negedge clk);
      if (i == 0) check("init_core_stall", 32'(core_stall), 32'd1);
      if (i == NREGS - 1) check("init_done_late", 32'(init_done), 32'd0);
    end
    @(negedge clk);
    check("init_done", 32'(init_done), 32'd1);
    check("run_core_stall", 32'(core_stall), 32'd0);
    check_swept("sweep_zero");

    // Core write to x5
    step();
    core_we = 1'b1; core_addr = 5'd5; core_data = 32'hDEAD_BEEF;
    push(5'd5, 32'hDEAD_BEEF);
    @(negedge clk);
    check("core_wr_stall", 32'(core_stall), 32'd0);
    check("core_wr_dbg_ready", 32'(dbg_ready), 32'd0);
    step();
    idle();
    @(negedge clk);
    check("x5_readback", rf_model[5], 32'hDEAD_BEEF);

`ifndef REGCTRL_RR_EN
    // Fixed priority: core wins three conflicts, debug lands on the fourth cycle
    for (int k = 0; k < 3; k++) begin
      step();
      core_we = 1'b1; core_addr = 5'd7; core_data = 32'h100 + 32'(k);
      dbg_valid = 1'b1; dbg_addr = 5'd9; dbg_data = 32'h55AA_55AA;
      push(5'd7, 32'h100 + 32'(k));
      @(negedge clk);
      check("fp_dbg_ready", 32'(dbg_ready), 32'd0);
      check("fp_core_stall", 32'(core_stall), 32'd0);
    end
    step();
    core_we = 1'b0;
    push(5'd9, 32'h55AA_55AA);
    @(negedge clk);
    check("fp_dbg_granted", 32'(dbg_ready), 32'd1);
    check("fp_conflict_cnt", 32'(conflict_cnt), 32'd3);
    step();
    idle();
    @(negedge clk);
    check("x9_readback", rf_model[9], 32'h55AA_55AA);
    check("x7_readback", rf_model[7], 32'h102);
`else
    // Round-robin: continuous conflict alternates core, dbg, core, dbg
    for (int k = 0; k < 4; k++) begin
      step();
      core_we = 1'b1; core_addr = 5'd3; core_data = 32'h300 + 32'(k);
      dbg_valid = 1'b1; dbg_addr = 5'd4; dbg_data = 32'h400 + 32'(k / 2);
      if (k % 2 == 0) push(5'd3, 32'h300 + 32'(k));
      else            push(5'd4, 32'h400 + 32'(k / 2));
      @(negedge clk);
      check("rr_core_stall", 32'(core_stall), (k % 2 == 0) ? 32'd0 : 32'd1);
      check("rr_dbg_ready", 32'(dbg_ready), (k % 2 == 0) ? 32'd0 : 32'd1);
    end
    step();
    idle();
    @(negedge clk);
    check("rr_conflict_cnt", 32'(conflict_cnt), 32'd4);
`endif

    // x0 protect: core and debug writes to x0 are dropped, debug still acknowledged
    step();
    core_we = 1'b1; core_addr = 5'd0; core_data = 32'h1234;
    @(negedge clk);
    check("x0_core_rf_we", 32'(rf_we), 32'd0);
    step();
    core_we = 1'b0;
    dbg_valid = 1'b1; dbg_addr = 5'd0; dbg_data = 32'hCAFE_F00D;
    @(negedge clk);
    check("x0_dbg_ready", 32'(dbg_ready), 32'd1);
    check("x0_dbg_rf_we", 32'(rf_we), 32'd0);
    step();
    idle();
    @(negedge clk);
    check("x0_readback", rf_model[0], 32'h0);

    // init_req in RUN: current core write completes, then a fresh sweep
    step();
    core_we = 1'b1; core_addr = 5'd6; core_data = 32'h66;
    init_req = 1'b1;
    push(5'd6, 32'h66);
    push_sweep();
    @(negedge clk);
    check("ireq_still_run", 32'(init_done), 32'd1);
    step();
    idle();
    @(negedge clk);
    check("ireq_init_done", 32'(init_done), 32'd0);
    check("ireq_core_stall", 32'(core_stall), 32'd1);

    // Reset pulse mid-sweep, once addr 10 is on the port
    repeat (10) @(negedge clk);
    #1;
    rst = 1'b0;
    check("midsweep_q_left", 32'(exp_q.size()), 32'd21);
    exp_q.delete();
    #1;
    check("midrst_rf_we", 32'(rf_we), 32'd0);
    check("midrst_init_done", 32'(init_done), 32'd0);
    check("midrst_dbg_ready", 32'(dbg_ready), 32'd0);
    check("midrst_core_stall", 32'(core_stall), 32'd1);
    check("midrst_conflict_cnt", 32'(conflict_cnt), 32'd0);
    step();
    push_sweep();
    rst = 1'b1;
    // init_req pulsed mid-sweep must be ignored; the monitor would see a restart
    for (int i = 0; i < NREGS; i++) begin
      @(negedge clk);
      if (i == 5) init_req = 1'b1;
      if (i == 6) init_req = 1'b0;
      if (i == NREGS - 1) check("resweep_init_done_late", 32'(init_done), 32'd0);
    end
    @(negedge clk);
    check("resweep_init_done", 32'(init_done), 32'd1);
    check_swept("resweep_zero");
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
